// File: rtl/seq_to_par.sv
// seq_to_par: serial-symbol to parallel-frame receiver.
// A frame begins with a start strobe seen in IDLE. After that, one WORD_SZ-wide
// symbol is sampled on every clock. The first symbol becomes bit 0 of par.
// A symbol that matches neither BIT0 nor BIT1 decodes as 0 and marks the
// frame as errored.
// Optional feature macro: SEQ_TO_PAR_PARITY_EN. When it is defined, one
// even-parity symbol follows the data symbols, and a parity mismatch sets err.
//
//   state  | meaning
//   IDLE   | waiting for start; par/err hold the last completed frame
//   ACTIVE | sampling data symbols 0..PAR_SZ-1
//   PARITY | sampling the even-parity symbol (SEQ_TO_PAR_PARITY_EN only)

module seq_to_par #(
  parameter int                 PAR_SZ  = 8,
  parameter int                 WORD_SZ = 1,
  parameter logic [WORD_SZ-1:0] BIT0    = WORD_SZ'(0),
  parameter logic [WORD_SZ-1:0] BIT1    = WORD_SZ'(1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WORD_SZ-1:0] seq,
  output logic [PAR_SZ-1:0]  par,
  output logic               valid,
  output logic               busy,
  output logic               err
);

  // The counter has one spare bit, so it can reach PAR_SZ without wrapping.
  localparam int               CNT_W    = $clog2(PAR_SZ) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAR_SZ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef SEQ_TO_PAR_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_ACTIVE = 2'd1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                ferr_q,  ferr_d;
  logic [PAR_SZ-1:0]   shift_q, shift_d;
  logic [PAR_SZ-1:0]   par_q,   par_d;
  logic                valid_q, valid_d;
  logic                busy_q,  busy_d;
  logic                err_q,   err_d;

  logic                sym_one;
  logic                sym_bad;

  // Symbol decode: anything other than BIT1 reads as 0; unknown codes flag an error
  always_comb begin
    sym_one = (seq == BIT1);
    sym_bad = (seq != BIT1) && (seq != BIT0);
  end

  // Next-state and datapath: symbols shift in at the MSB, so symbol 0 lands in bit 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ferr_d  = ferr_q;
    shift_d = shift_q;
    par_d   = par_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          ferr_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_ACTIVE: begin
        shift_d = {sym_one, shift_q[PAR_SZ-1:1]};
        ferr_d  = ferr_q | sym_bad;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_IDX) begin
`ifdef SEQ_TO_PAR_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
          par_d   = shift_d;
          err_d   = ferr_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
`endif
        end
      end

`ifdef SEQ_TO_PAR_PARITY_EN
      ST_PARITY: begin
        // Even parity: the data bits XORed with the parity bit must give 0
        state_d = ST_IDLE;
        par_d   = shift_q;
        err_d   = ferr_q | sym_bad | ((^shift_q) ^ sym_one);
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any partial frame without a valid pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign par   = par_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seq_to_par.sv
// Directed bench for seq_to_par (PAR_SZ=8, WORD_SZ=2, BIT0=01, BIT1=10).
// It also covers the parity build when SEQ_TO_PAR_PARITY_EN is defined.

module tb_seq_to_par;

  localparam int         PAR_SZ  = 8;
  localparam int         WORD_SZ = 2;
  localparam logic [1:0] S0      = 2'b01;
  localparam logic [1:0] S1      = 2'b10;
`ifdef SEQ_TO_PAR_PARITY_EN
  localparam int         FRAME_LEN = PAR_SZ + 1;
`else
  localparam int         FRAME_LEN = PAR_SZ;
`endif

  logic               clk;
  logic               reset;
  logic               start;
  logic [WORD_SZ-1:0] seq;
  logic [PAR_SZ-1:0]  par;
  logic               valid;
  logic               busy;
  logic               err;

  int n_checks;
  int n_err;
  int gap_cnt;
  int busy_low_cnt;
  int vcnt;

  seq_to_par #(
    .PAR_SZ (PAR_SZ),
    .WORD_SZ(WORD_SZ),
    .BIT0   (S0),
    .BIT1   (S1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .seq  (seq),
    .par  (par),
    .valid(valid),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives start and one full frame. It returns at the negedge that follows the
  // completing edge, which is the cycle where valid should be high. gap_cnt
  // counts the sampled cycles before that point with valid low; busy_low_cnt
  // counts the cycles with busy low.
  task automatic send_frame(input logic [7:0] data, input int bad_idx,
                            input logic [1:0] bad_sym, input int mid_start_idx,
                            input logic [1:0] par_sym);
    gap_cnt      = 0;
    busy_low_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    if (!valid) gap_cnt++;
    if (!busy)  busy_low_cnt++;
    for (int k = 0; k < PAR_SZ; k++) begin
      seq   = (k == bad_idx) ? bad_sym : (data[k] ? S1 : S0);
      start = (k == mid_start_idx);
      @(negedge clk);
`ifdef SEQ_TO_PAR_PARITY_EN
      if (!valid) gap_cnt++;
      if (!busy)  busy_low_cnt++;
`else
      if (k < PAR_SZ - 1) begin
        if (!valid) gap_cnt++;
        if (!busy)  busy_low_cnt++;
      end
`endif
    end
`ifdef SEQ_TO_PAR_PARITY_EN
    seq   = par_sym;
    start = 1'b0;
    @(negedge clk);
`else
    if (par_sym == 2'b11) seq = S0;
`endif
    start = 1'b0;
    seq   = S0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b0;
    start    = 1'b0;
    seq      = S0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_par",   32'(par),   32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_err",   32'(err),   32'h0);
    reset = 1'b1;

    // start=0 keeps IDLE
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // Frame A5, clean
    send_frame(8'hA5, -1, 2'b00, -1, S0);
    chk("a5_valid", 32'(valid), 32'h1);
    chk("a5_par",   32'(par),   32'hA5);
    chk("a5_err",   32'(err),   32'h0);
    chk("a5_busy",  32'(busy),  32'h0);
    chk("a5_gap",   32'(gap_cnt), 32'(FRAME_LEN));
    chk("a5_busy_hold", 32'(busy_low_cnt), 32'h0);
    @(negedge clk);
    chk("a5_valid_pulse", 32'(valid), 32'h0);
    chk("a5_par_hold",    32'(par),   32'hA5);

    // Frame FF with symbol 3 illegal
    send_frame(8'hFF, 3, 2'b11, -1, S0);
    chk("bad_valid", 32'(valid), 32'h1);
    chk("bad_par",   32'(par),   32'hF7);
    chk("bad_err",   32'(err),   32'h1);
    chk("bad_gap",   32'(gap_cnt), 32'(FRAME_LEN));
    @(negedge clk);
    chk("bad_err_hold", 32'(err), 32'h1);

    // Reset after 4 symbols
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seq = S1;
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("mid_rst_par",   32'(par),   32'h0);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_busy",  32'(busy),  32'h0);
    chk("mid_rst_err",   32'(err),   32'h0);
    @(negedge clk);
    reset = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      seq = k[0] ? S1 : S0;
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("mid_rst_no_valid", 32'(vcnt), 32'h0);
    seq = S0;

    send_frame(8'h3C, -1, 2'b00, -1, S0);
    chk("3c_valid", 32'(valid), 32'h1);
    chk("3c_par",   32'(par),   32'h3C);
    chk("3c_err",   32'(err),   32'h0);
    @(negedge clk);

    // Mid-frame start is ignored; start in the valid cycle begins the next frame
    send_frame(8'hFF, -1, 2'b00, 4, S0);
    chk("ff_valid", 32'(valid), 32'h1);
    chk("ff_par",   32'(par),   32'hFF);
    chk("ff_gap",   32'(gap_cnt), 32'(FRAME_LEN));
    send_frame(8'h00, -1, 2'b00, -1, S0);
    chk("b2b_valid", 32'(valid), 32'h1);
    chk("b2b_par",   32'(par),   32'h00);
    chk("b2b_gap",   32'(gap_cnt), 32'(FRAME_LEN));
    chk("b2b_err",   32'(err),   32'h0);
    chk("b2b_busy_hold", 32'(busy_low_cnt), 32'h0);
    @(negedge clk);

`ifdef SEQ_TO_PAR_PARITY_EN
    // Parity: A5 has even weight, so BIT0 is correct and BIT1 is wrong
    send_frame(8'hA5, -1, 2'b00, -1, S0);
    chk("p_ok_valid", 32'(valid), 32'h1);
    chk("p_ok_err",   32'(err),   32'h0);
    chk("p_ok_gap",   32'(gap_cnt), 32'd9);
    @(negedge clk);
    send_frame(8'hA5, -1, 2'b00, -1, S1);
    chk("p_bad_valid", 32'(valid), 32'h1);
    chk("p_bad_par",   32'(par),   32'hA5);
    chk("p_bad_err",   32'(err),   32'h1);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
